sync_fifo_param: RTL
====================

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of the write and read data in bits.
REQ-002 SHALL have parameter DEPTH, default 16: number of entries, a power of two, minimum 4.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2: almost_full asserts when count is at or above this value.
REQ-004 SHALL have parameter AE_LEVEL, default 2: almost_empty asserts when count is at or below this value.
REQ-005 SHALL have clk, input, 1 bit: the single clock; all logic uses the rising edge only.
REQ-006 SHALL have rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have wr_en, input, 1 bit: write request.
REQ-008 SHALL have wdata, input, DATA_WIDTH bits: write data, sampled when wr_en is high.
REQ-009 SHALL have rd_en, input, 1 bit: read request.
REQ-010 SHALL have rdata, output, DATA_WIDTH bits: registered read data.
REQ-011 SHALL have rd_valid, output, 1 bit: rdata holds a newly popped word this cycle.
REQ-012 SHALL have full, empty, almost_full and almost_empty as outputs, 1 bit each: status flags.
REQ-013 SHALL have count, output, $clog2(DEPTH)+1 bits: number of stored entries.
REQ-014 SHALL have overflow and underflow as outputs, 1 bit each: single-cycle error pulses.

Function
REQ-015 SHALL accept a write on a rising edge when wr_en=1 and full=0, and store wdata at the write pointer.
REQ-016 SHALL accept a read on a rising edge when rd_en=1 and empty=0, and load the word at the read pointer into rdata at that edge.
REQ-017 SHALL set rd_valid=1 for exactly the cycle after each accepted read, and 0 otherwise.
REQ-018 SHALL hold rdata unchanged when no read is accepted.
REQ-019 SHALL use read and write pointers of $clog2(DEPTH)+1 bits; the MSB is a wrap bit and the low bits address the memory.
REQ-020 SHALL wrap each pointer from DEPTH-1 to 0 and toggle its wrap bit.
REQ-021 SHALL derive empty when the two pointers are equal; all bits are compared.
REQ-022 SHALL derive full when the low bits of the pointers are equal and the wrap bits differ.
REQ-023 SHALL update count as +1 for a write only, -1 for a read only, and unchanged for both or neither; count stays in the range 0..DEPTH.
REQ-024 SHALL drive all flags as registered outputs, consistent with count in the same cycle.
REQ-025 SHALL, when full and wr_en=1 and rd_en=1, accept the read, reject the write, and pulse overflow.
REQ-026 SHALL, when empty and wr_en=1 and rd_en=1, accept the write, reject the read, and pulse underflow; rd_valid stays 0.
REQ-027 SHALL, when neither full nor empty and both requests are high, accept both, leave count unchanged, and advance both pointers.
REQ-028 SHALL pulse overflow for one cycle on a rejected write (wr_en=1 while full), and leave memory and pointers unchanged.
REQ-029 SHALL pulse underflow for one cycle on a rejected read (rd_en=1 while empty), and leave rdata unchanged.
REQ-030 SHALL produce first-in first-out ordering with no word lost or duplicated across pointer wrap.

Reset
REQ-031 SHALL, on a rising edge with rst=1, clear both pointers and count to 0.
REQ-032 SHALL, on the same reset edge, set empty=1 and almost_empty=1.
REQ-033 SHALL, on the same reset edge, clear full, almost_full, rd_valid, overflow, underflow and rdata to 0.
REQ-034 SHALL let rst override wr_en and rd_en on the same edge; memory contents need not be cleared.
REQ-035 SHALL discard all stored data when reset is applied mid-operation; the FIFO reads as empty on the next cycle.

Verification
REQ-036 SHALL cover: reset, then write 0x01..0x10 (16 words) -> full=1, count=16, almost_full first high after the 14th write, no overflow.
REQ-037 SHALL cover: from full, 16 reads -> rdata 0x01..0x10 in order, each with rd_valid one cycle after its read, then empty=1 and almost_empty=1.
REQ-038 SHALL cover: full plus wr_en=1 and rd_en=1 -> overflow pulse, count=15, the head word popped, and the rejected wdata never read.
REQ-039 SHALL cover: empty plus rd_en=1 -> underflow pulse, rd_valid=0 and rdata unchanged; adding wr_en=1 -> count=1.
REQ-040 SHALL cover: 40 random interleaved writes and reads (pointer wrap) -> matches a reference queue model, with count always equal to the model size.
REQ-041 SHALL cover: write 5 words, assert rst for 1 cycle -> count=0, empty=1, all outputs at reset values, and the next write/read returns the new word.

Source files
------------

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parameterised synchronous FIFO with registered status flags and overflow/underflow pulses
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rd_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] ONE    = {{PW{1'b0}}, 1'b1};
    localparam logic [PW:0] AF_THR = AF_LEVEL[PW:0];
    localparam logic [PW:0] AE_THR = AE_LEVEL[PW:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic                  full_q, full_d, empty_q, empty_d, af_q, af_d, ae_q, ae_d;
    logic                  rd_valid_q, ovf_q, udf_q, wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Accept requests against the registered flags, then derive next pointers, count and flags
    always_comb begin
        wr_acc   = wr_en && !full_q;
        rd_acc   = rd_en && !empty_q;
        wr_ptr_d = wr_acc ? wr_ptr_q + ONE : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + ONE : rd_ptr_q;
        count_d  = (wr_acc && !rd_acc) ? count_q + ONE :
                   (rd_acc && !wr_acc) ? count_q - ONE : count_q;
        empty_d  = wr_ptr_d == rd_ptr_d;
        full_d   = (wr_ptr_d[PW-1:0] == rd_ptr_d[PW-1:0]) && (wr_ptr_d[PW] != rd_ptr_d[PW]);
        af_d     = count_d >= AF_THR;
        ae_d     = count_d <= AE_THR;
    end

    // Storage array; contents survive reset since pointers alone define occupancy
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem[wr_ptr_q[PW-1:0]] <= wdata;
    end

    // State, read data and status registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
            if (rd_acc) rdata_q <= mem[rd_ptr_q[PW-1:0]];
            rd_valid_q <= rd_acc;
            ovf_q      <= wr_en && full_q;
            udf_q      <= rd_en && empty_q;
        end
    end

    assign rdata        = rdata_q;
    assign rd_valid     = rd_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
endmodule
